// File: rtl/serial_word_assembler_if.sv
// serial_word_assembler_if
//   Bundles the serial input side and the parallel valid/ready output side of
//   serial_word_assembler.
//   slave  modport: the assembler (receives bits, drives the word bus).
//   master modport: the producer/consumer environment around it.
//   Signals:
//     bit_in, bit_valid : serial bit and its qualifier
//     flush             : drop the partial word being collected
//     ovf_clear         : clear the sticky overflow flag
//     data, data_valid  : assembled word and its valid flag
//     data_ready        : consumer accepts data this cycle
//     bit_count         : bits collected in the current partial word
//     overflow          : sticky, a completed word was dropped
interface serial_word_assembler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
);
    logic                  bit_in;
    logic                  bit_valid;
    logic                  flush;
    logic                  ovf_clear;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  data_ready;
    logic [CNT_WIDTH-1:0]  bit_count;
    logic                  overflow;

    modport slave (
        input  bit_in, bit_valid, flush, ovf_clear, data_ready,
        output data, data_valid, bit_count, overflow
    );

    modport master (
        output bit_in, bit_valid, flush, ovf_clear, data_ready,
        input  data, data_valid, bit_count, overflow
    );
endinterface

// File: rtl/serial_word_assembler.sv
// serial_word_assembler
//   Collects a serial bit stream (MSB first) into DATA_WIDTH-bit words and
//   presents each completed word through a one-word output holding register
//   with a valid/ready handshake. Collection keeps running while the consumer
//   stalls; a word completed while the holding register is still occupied and
//   not being drained is dropped and the sticky overflow flag is raised.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high reset; clears all state
//     bus   : serial_word_assembler_if.slave (bit input, word output bus)
module serial_word_assembler #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    serial_word_assembler_if.slave   bus
);

    generate
        if (DATA_WIDTH < 2) begin : g_bad_width
            $error("DATA_WIDTH must be at least 2");
        end
        if ((2 ** CNT_WIDTH) <= DATA_WIDTH) begin : g_bad_cnt
            $error("CNT_WIDTH too small to count DATA_WIDTH bits");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  data_valid_q;
    logic                  ovf_q;
    out_state_t            state_q;

    logic [DATA_WIDTH-1:0] word;
    logic                  complete;

    // The word formed by this cycle's bit; only meaningful when complete=1.
    assign word     = {sh_q[DATA_WIDTH-2:0], bus.bit_in};
    // Flush wins over a bit offered in the same cycle, so it also
    // suppresses completion.
    assign complete = bus.bit_valid && !bus.flush && (cnt_q == LAST_IDX);

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (bus.bit_valid) begin
            sh_d  = word;
            cnt_d = complete ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    // Output holding register. data is only loaded on completion, so it
    // keeps its last value after a transfer and stays stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (bus.ovf_clear) begin
                ovf_q <= 1'b0;
            end
            case (state_q)
                EMPTY: begin
                    if (complete) begin
                        data_q       <= word;
                        state_q      <= FULL;
                        data_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (complete) begin
                        if (bus.data_ready) begin
                            // Old word leaves this edge, new one takes its
                            // place without a bubble.
                            data_q <= word;
                        end else begin
                            // Drop the new word; a drop on the same edge as
                            // ovf_clear must leave the flag set.
                            ovf_q <= 1'b1;
                        end
                    end else if (bus.data_ready) begin
                        state_q      <= EMPTY;
                        data_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= EMPTY;
                    data_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.bit_count  = cnt_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;
    localparam int DW = 32;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic reset;

    serial_word_assembler_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) sig ();

    serial_word_assembler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sig)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: words the consumer should see, in order.
    logic [DW-1:0] exp_q[$];
    // Reference model state for what the bench has fed in.
    logic [DW-1:0] m_sh;
    int            m_cnt;
    bit            m_full;

    function automatic logic [DW-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_sh   = '0;
        m_cnt  = 0;
        m_full = 1'b0;
    endtask

    // Update the model with the inputs about to be sampled, then advance one
    // edge; outputs are read 1 time unit after the edge.
    task automatic tick();
        logic          comp;
        logic [DW-1:0] w;
        comp = sig.bit_valid && !sig.flush && (m_cnt == DW - 1);
        w    = {m_sh[DW-2:0], sig.bit_in};
        if (sig.flush) begin
            m_sh  = '0;
            m_cnt = 0;
        end else if (sig.bit_valid) begin
            m_sh  = w;
            m_cnt = comp ? 0 : m_cnt + 1;
        end
        if (comp) begin
            if (!m_full || sig.data_ready) begin
                m_full = 1'b1;
                exp_q.push_back(w);
            end
        end else if (sig.data_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Shift the low n bits of w, MSB first; with gaps an idle cycle (random
    // bit_in, bit_valid=0) precedes each bit.
    task automatic shift_bits(input logic [DW-1:0] w, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) begin
                sig.bit_valid = 1'b0;
                sig.bit_in    = 1'($urandom_range(1, 0));
                tick();
            end
            sig.bit_valid = 1'b1;
            sig.bit_in    = w[i];
            tick();
        end
        sig.bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        sig.bit_in     = 1'b0;
        sig.bit_valid  = 1'b0;
        sig.flush      = 1'b0;
        sig.ovf_clear  = 1'b0;
        sig.data_ready = 1'b0;
        model_clear();
        #2;
        checks++;
        if (sig.data !== '0 || sig.data_valid !== 1'b0 || sig.bit_count !== '0 || sig.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: data=%h valid=%b cnt=%0d ovf=%b required all zero",
                     sig.data, sig.data_valid, sig.bit_count, sig.overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        $display("test_reset: outputs zero while reset held");
    endtask

    task automatic test_single_word();
        logic [DW-1:0] exp;
        sig.data_ready = 1'b0;
        shift_bits(32'h8AAA8657 >> 1, 31, 1'b0);
        checks++;
        if (sig.data_valid !== 1'b0 || sig.bit_count !== CW'(31)) begin
            failures++;
            $display("FAIL single_pre: valid=%b cnt=%0d required valid=0 cnt=31",
                     sig.data_valid, sig.bit_count);
        end
        sig.bit_valid = 1'b1;
        sig.bit_in    = 1'b1;
        tick();
        sig.bit_valid = 1'b0;
        exp = pop_exp();
        checks++;
        if (sig.data !== exp || sig.data_valid !== 1'b1 || sig.bit_count !== '0 || sig.overflow !== 1'b0) begin
            failures++;
            $display("FAIL single_word: data=%h valid=%b cnt=%0d ovf=%b required data=%h valid=1 cnt=0 ovf=0",
                     sig.data, sig.data_valid, sig.bit_count, sig.overflow, exp);
        end
        $display("test_single_word: word %h", sig.data);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (sig.data !== 32'h8AAA8657 || sig.data_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cycle %0d: data=%h valid=%b required 8aaa8657 valid=1",
                         i, sig.data, sig.data_valid);
            end
        end
        sig.data_ready = 1'b1;
        tick();
        sig.data_ready = 1'b0;
        checks++;
        if (sig.data_valid !== 1'b0 || sig.data !== 32'h8AAA8657) begin
            failures++;
            $display("FAIL stall_release: valid=%b data=%h required valid=0 data=8aaa8657",
                     sig.data_valid, sig.data);
        end
        // data_ready while empty must not change anything
        sig.data_ready = 1'b1;
        tick();
        sig.data_ready = 1'b0;
        checks++;
        if (sig.data_valid !== 1'b0 || sig.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ready_when_empty: valid=%b ovf=%b required 0 0", sig.data_valid, sig.overflow);
        end
        $display("test_stall: held 10 cycles then transferred");
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp;
        sig.data_ready = 1'b0;
        shift_bits(32'h8AAA8657, 32, 1'b0);
        shift_bits(32'h12345678 >> 1, 31, 1'b0);
        checks++;
        if (sig.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_early: ovf=%b required 0", sig.overflow);
        end
        sig.bit_valid = 1'b1;
        sig.bit_in    = 1'b0;
        tick();
        sig.bit_valid = 1'b0;
        exp = pop_exp();
        checks++;
        if (sig.data !== exp || sig.data_valid !== 1'b1 || sig.overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_drop: data=%h valid=%b ovf=%b required data=%h valid=1 ovf=1",
                     sig.data, sig.data_valid, sig.overflow, exp);
        end
        sig.ovf_clear = 1'b1;
        tick();
        sig.ovf_clear = 1'b0;
        checks++;
        if (sig.overflow !== 1'b0 || sig.data_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b valid=%b required ovf=0 valid=1", sig.overflow, sig.data_valid);
        end
        // Drop coinciding with ovf_clear: set must win.
        shift_bits(32'h0F0F0F0F >> 1, 31, 1'b0);
        sig.bit_valid = 1'b1;
        sig.bit_in    = 1'b1;
        sig.ovf_clear = 1'b1;
        tick();
        sig.bit_valid = 1'b0;
        sig.ovf_clear = 1'b0;
        checks++;
        if (sig.overflow !== 1'b1 || sig.data !== 32'h8AAA8657) begin
            failures++;
            $display("FAIL ovf_set_wins: ovf=%b data=%h required ovf=1 data=8aaa8657", sig.overflow, sig.data);
        end
        sig.ovf_clear = 1'b1;
        tick();
        sig.ovf_clear  = 1'b0;
        sig.data_ready = 1'b1;
        tick();
        sig.data_ready = 1'b0;
        checks++;
        if (sig.data_valid !== 1'b0 || sig.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain: valid=%b ovf=%b required 0 0", sig.data_valid, sig.overflow);
        end
        $display("test_overflow: drop flagged and cleared");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] stream [2];
        logic [DW-1:0] exp;
        int n_valid;
        int idx [2];
        stream[0] = 32'hFFFFFFFF;
        stream[1] = 32'h00000001;
        n_valid = 0;
        idx[0] = -1;
        idx[1] = -1;
        sig.data_ready = 1'b1;
        for (int c = 0; c < 65; c++) begin
            sig.bit_valid = (c < 64);
            sig.bit_in    = (c < 64) ? stream[c / 32][31 - (c % 32)] : 1'b0;
            tick();
            if (sig.data_valid === 1'b1) begin
                if (n_valid < 2) idx[n_valid] = c;
                n_valid++;
                exp = pop_exp();
                checks++;
                if (sig.data !== exp) begin
                    failures++;
                    $display("FAIL b2b_data cycle %0d: data=%h required %h", c, sig.data, exp);
                end
            end
        end
        sig.data_ready = 1'b0;
        sig.bit_valid  = 1'b0;
        checks++;
        if (n_valid !== 2 || idx[1] - idx[0] !== 32 || sig.overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_timing: valid_cycles=%0d spacing=%0d ovf=%b required 2 32 0",
                     n_valid, idx[1] - idx[0], sig.overflow);
        end
        $display("test_back_to_back: %0d words, spacing %0d", n_valid, idx[1] - idx[0]);
    endtask

    task automatic test_flush();
        logic [DW-1:0] exp;
        sig.data_ready = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            shift_bits(32'($urandom()), 12, 1'b0);
            checks++;
            if (sig.bit_count !== CW'(12)) begin
                failures++;
                $display("FAIL flush_pre pass %0d: cnt=%0d required 12", pass, sig.bit_count);
            end
            sig.flush     = 1'b1;
            sig.bit_valid = 1'b1;
            sig.bit_in    = 1'b1;
            tick();
            sig.flush     = 1'b0;
            sig.bit_valid = 1'b0;
            checks++;
            if (sig.bit_count !== '0) begin
                failures++;
                $display("FAIL flush_count pass %0d: cnt=%0d required 0", pass, sig.bit_count);
            end
            if (pass == 0) begin
                shift_bits(32'hA5A5A5A5, 32, 1'b0);
            end else begin
                // 63 cycles in: 31 bits with gaps plus the final gap cycle.
                shift_bits(32'hA5A5A5A5 >> 1, 31, 1'b1);
                sig.bit_valid = 1'b0;
                tick();
                checks++;
                if (sig.data_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_early: valid=%b required 0 at cycle 63", sig.data_valid);
                end
                sig.bit_valid = 1'b1;
                sig.bit_in    = 1'b1;
                tick();
                sig.bit_valid = 1'b0;
            end
            exp = pop_exp();
            checks++;
            if (sig.data !== exp || sig.data_valid !== 1'b1) begin
                failures++;
                $display("FAIL flush_word pass %0d: data=%h valid=%b required %h valid=1",
                         pass, sig.data, sig.data_valid, exp);
            end
            sig.data_ready = 1'b1;
            tick();
            sig.data_ready = 1'b0;
            $display("test_flush pass %0d: word %h", pass, sig.data);
        end
    endtask

    task automatic test_async_reset();
        sig.data_ready = 1'b0;
        shift_bits(32'h13579BDF, 32, 1'b0);
        shift_bits(32'h2468ACE0, 32, 1'b0);
        shift_bits(32'h0001FFFF, 17, 1'b0);
        checks++;
        if (sig.data_valid !== 1'b1 || sig.bit_count !== CW'(17) || sig.overflow !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: valid=%b cnt=%0d ovf=%b required 1 17 1",
                     sig.data_valid, sig.bit_count, sig.overflow);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (sig.data !== '0 || sig.data_valid !== 1'b0 || sig.bit_count !== '0 || sig.overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: data=%h valid=%b cnt=%0d ovf=%b required all zero",
                     sig.data, sig.data_valid, sig.bit_count, sig.overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        tick();
        checks++;
        if (sig.data_valid !== 1'b0 || sig.bit_count !== '0) begin
            failures++;
            $display("FAIL async_after: valid=%b cnt=%0d required 0 0", sig.data_valid, sig.bit_count);
        end
        $display("test_async_reset: cleared before clock edge");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Upstream feeder for the up/down counter stage.
- Collects a serial bit stream, MSB first, into DATA_WIDTH-bit words and presents each completed word on a parallel `data` bus with a valid/ready handshake.
- A one-word output holding register lets bit collection continue while the consumer stalls.
- A sticky overflow flag reports any word lost to back-pressure.

Parameters:
- DATA_WIDTH, 32, width of the assembled word. Must be ≥ 2.
- CNT_WIDTH, 6, width of the bit counter. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- bit_in  input  1  serial data bit, sampled only when bit_valid=1
- bit_valid  input  1  qualifies bit_in for the current cycle
- flush  input  1  discards the partial word in the shift register
- ovf_clear  input  1  clears the sticky overflow flag
- data  output  DATA_WIDTH  assembled word; the first received bit sits in the MSB
- data_valid  output  1  data holds an untransferred word
- data_ready  input  1  consumer accepts data this cycle
- bit_count  output  CNT_WIDTH  number of bits in the current partial word
- overflow  output  1  sticky; a completed word was dropped

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - While reset=1: shift register=0, bit_count=0, data=0, data_valid=0, overflow=0, with no clock edge required.
  - Normal operation resumes at the first rising edge after reset deasserts.
  - Reset asserted mid-word or mid-handshake discards all content.
- Shift path (per rising edge, flush=0, bit_valid=1):
  - sh <= {sh[DATA_WIDTH-2:0], bit_in}
  - bit_count increments.
  - bit_valid=0: shift register and count hold.
- Word completion:
  - Occurs when bit_valid=1 and bit_count==DATA_WIDTH-1.
  - Completed word = {sh[DATA_WIDTH-2:0], bit_in}; bit_count returns to 0 on the same edge.
  - Latency: the word appears on data with data_valid=1 in the cycle after the edge that sampled the last bit.
- Output register, two states:
  - EMPTY (data_valid=0) and FULL (data_valid=1).
  - EMPTY -> FULL on word completion.
  - FULL -> EMPTY on an edge where data_ready=1 and no word completes.
  - FULL -> FULL with new data on an edge where data_ready=1 and a word completes (back-to-back, no bubble).
  - FULL with data_ready=0 and a word completing: the new word is dropped, data keeps the old value, and overflow <= 1.
- Handshake:
  - A transfer occurs on any edge with data_valid=1 and data_ready=1.
  - data must stay stable while data_valid=1 and data_ready=0.
  - data_ready while EMPTY has no effect.
  - data retains its last value after a transfer; consumers must ignore it while data_valid=0.
- Flush:
  - Sets sh=0 and bit_count=0 on the edge.
  - Takes priority over bit_valid; a bit offered in the same cycle is discarded.
  - Does not affect data, data_valid, or overflow.
- Overflow:
  - Sticky; cleared only by reset or ovf_clear.
  - If ovf_clear and a new drop occur on the same edge, overflow=1 (set wins).
- bit_count never reaches DATA_WIDTH; its wrap is to 0 at completion.

Test Plan:
1. Reset, then shift 32'h8AAA8657 (bits 1,0,0,0,1,0,1,0,…,0,1,1,1) MSB first with bit_valid=1 every cycle and data_ready=0 -> one cycle after the 32nd bit, data=32'h8AAA8657, data_valid=1, bit_count=0, overflow=0.
2. Hold data_ready=0 for 10 cycles after scenario 1, then pulse data_ready for one cycle -> data stays 32'h8AAA8657 during the stall; data_valid=0 the cycle after the pulse.
3. Keep data_ready=0 and shift two full words, 32'h8AAA8657 then 32'h12345678 -> data stays 32'h8AAA8657, overflow=1 one cycle after the 64th bit. Pulse ovf_clear with no completion -> overflow=0.
4. Hold data_ready=1 and stream 32'hFFFFFFFF then 32'h00000001 continuously -> data_valid=1 for exactly one cycle per word, the second word appears 32 cycles after the first, overflow=0.
5. Shift 12 bits, assert flush together with bit_valid=1, then shift 32'hA5A5A5A5 -> bit_count=0 after the flush edge and output is 32'hA5A5A5A5 with no remnant of the 12 bits. Repeat with bit_valid gaps (every other cycle) -> same word, completion after 64 cycles.
6. Assert reset asynchronously mid-cycle while data_valid=1, bit_count=17, overflow=1 -> all outputs 0 immediately, before the next clock edge.
